mux_2to1_arb: RTL and testbench

MUX_2TO1_ARB -- requirements
Module: mux_2to1_arb

---
 rtl/mux_2to1_arb_if.sv | 26 ++
 rtl/mux_2to1_arb.sv | 80 ++++++++
 tb/tb_mux_2to1_arb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_2to1_arb_if.sv
// Handshake bundle for mux_2to1_arb: two valid/ready input channels and one
// registered valid/ready output channel. master = traffic source/sink side, slave = arbiter.
interface mux_2to1_arb_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             sel;

    modport master (
        output a_data, a_valid, b_data, b_valid, y_ready,
        input  a_ready, b_ready, y, y_valid, sel
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, y_ready,
        output a_ready, b_ready, y, y_valid, sel
    );
endinterface

// File: rtl/mux_2to1_arb.sv
// Two-input valid/ready arbiter feeding a one-entry output register.
// Ties go round-robin; defining MUX_ARB_FIXED_PRIO_EN makes A always win ties.
module mux_2to1_arb #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_2to1_arb_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] y_reg;
    logic             sel_reg;

    logic             load_en;
    logic             prefer_a;
    logic             gnt_a;
    logic             gnt_b;
    logic             take_a;
    logic             take_b;
    logic [WIDTH-1:0] load_data;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign prefer_a = 1'b1;
`else
    // last_gnt_reg: 0 = A granted last, 1 = B granted last
    logic last_gnt_reg;
    assign prefer_a = last_gnt_reg;
`endif

    // The output register can accept a word when empty or when it is being drained.
    assign load_en = (state_reg == EMPTY) || bus.y_ready;

    always_comb begin
        gnt_a  = bus.a_valid && (!bus.b_valid || prefer_a);
        gnt_b  = bus.b_valid && !gnt_a;
        take_a = rst_n && load_en && gnt_a;
        take_b = rst_n && load_en && gnt_b;
    end

    assign bus.a_ready = take_a;
    assign bus.b_ready = take_b;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load_mux
        assign load_data[gi] = take_b ? bus.b_data[gi] : bus.a_data[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            y_reg        <= '0;
            sel_reg      <= 1'b0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_gnt_reg <= 1'b1;
`endif
        end else if (load_en) begin
            if (take_a || take_b) begin
                state_reg    <= FULL;
                y_reg        <= load_data;
                sel_reg      <= take_b;
`ifndef MUX_ARB_FIXED_PRIO_EN
                last_gnt_reg <= take_b;
`endif
            end else begin
                // Drained with nothing to refill: payload and sel are kept as-is.
                state_reg <= EMPTY;
            end
        end
    end

    assign bus.y       = y_reg;
    assign bus.sel     = sel_reg;
    assign bus.y_valid = (state_reg == FULL);

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Self-checking bench for mux_2to1_arb: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_mux_2to1_arb;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mux_2to1_arb_if #(.WIDTH(WIDTH)) bus ();

    mux_2to1_arb #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one-word holding register plus "who was served last".
    bit         m_full;
    logic [7:0] m_y;
    bit         m_sel;
    bit         m_last_b;

`ifdef MUX_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    function automatic bit exp_a_ready();
        bit can_load;
        bit a_wins;
        can_load = rst_n && (!m_full || bus.y_ready);
        a_wins   = bus.a_valid && (!bus.b_valid || FIXED || m_last_b);
        return can_load && a_wins;
    endfunction

    function automatic bit exp_b_ready();
        bit can_load;
        bit a_wins;
        can_load = rst_n && (!m_full || bus.y_ready);
        a_wins   = bus.a_valid && (!bus.b_valid || FIXED || m_last_b);
        return can_load && bus.b_valid && !a_wins;
    endfunction

    task automatic drive(input bit rn, input bit av, input logic [7:0] ad,
                         input bit bv, input logic [7:0] bd, input bit yr);
        rst_n       = rn;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.y_ready = yr;
        #3;
    endtask

    // Advance one edge and update the model from the inputs held across it.
    task automatic tick();
        bit xa;
        bit xb;
        xa = exp_a_ready();
        xb = exp_b_ready();
        @(posedge clk);
        if (!rst_n) begin
            m_full = 0; m_y = 8'h00; m_sel = 0; m_last_b = 1;
        end else if (xa) begin
            m_full = 1; m_y = bus.a_data; m_sel = 0; m_last_b = 0;
            $display("xfer ch=A data=%02h", bus.a_data);
        end else if (xb) begin
            m_full = 1; m_y = bus.b_data; m_sel = 1; m_last_b = 1;
            $display("xfer ch=B data=%02h", bus.b_data);
        end else if (m_full && bus.y_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 0, 8'h00, 0);
        tick();
        drive(1, 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic test_reset();
        drive(0, 1, 8'h5A, 1, 8'hA5, 1);
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_readies: a_ready=%b b_ready=%b required 0 0", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.y !== 8'h00 || bus.sel !== 1'b0 || bus.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: y=%02h sel=%b y_valid=%b required 00 0 0", bus.y, bus.sel, bus.y_valid);
        end
        drive(1, 0, 8'h00, 0, 8'h00, 0);
    endtask

    task automatic test_single_a();
        do_reset();
        drive(1, 1, 8'h11, 0, 8'h00, 1);
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_a_ready: a_ready=%b b_ready=%b required 1 0", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.y !== 8'h11 || bus.sel !== 1'b0 || bus.y_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_a_out: y=%02h sel=%b y_valid=%b required 11 0 1", bus.y, bus.sel, bus.y_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_cnt;
        logic [7:0] b_cnt;
        logic [7:0] exp_y;
        bit         exp_s;
        do_reset();
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 8'hA0 + a_cnt, 1, 8'hB0 + b_cnt, 1);
            exp_s = FIXED ? 1'b0 : bit'(i % 2);
            exp_y = exp_s ? 8'hB0 + b_cnt : 8'hA0 + a_cnt;
            checks++;
            if (bus.a_ready !== !exp_s || bus.b_ready !== exp_s) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: a_ready=%b b_ready=%b required %b %b",
                         i, bus.a_ready, bus.b_ready, !exp_s, exp_s);
            end
            tick();
            checks++;
            if (bus.y_valid !== 1'b1 || bus.sel !== exp_s || bus.y !== exp_y) begin
                errors++;
                $display("FAIL b2b_out[%0d]: y=%02h sel=%b y_valid=%b required %02h %b 1",
                         i, bus.y, bus.sel, bus.y_valid, exp_y, exp_s);
            end
            if (exp_s) b_cnt++;
            else       a_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, 1, 8'h11, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h00, 1, 8'hB7, 0);
            checks++;
            if (bus.b_ready !== 1'b0 || bus.a_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready[%0d]: a_ready=%b b_ready=%b required 0 0", i, bus.a_ready, bus.b_ready);
            end
            tick();
            checks++;
            if (bus.y !== 8'h11 || bus.sel !== 1'b0 || bus.y_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: y=%02h sel=%b y_valid=%b required 11 0 1",
                         i, bus.y, bus.sel, bus.y_valid);
            end
        end
        drive(1, 0, 8'h00, 1, 8'hB7, 1);
        checks++;
        if (bus.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: b_ready=%b required 1", bus.b_ready);
        end
        tick();
        checks++;
        if (bus.y !== 8'hB7 || bus.sel !== 1'b1 || bus.y_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_out: y=%02h sel=%b y_valid=%b required b7 1 1", bus.y, bus.sel, bus.y_valid);
        end
    endtask

    task automatic test_drain();
        drive(1, 0, 8'h00, 0, 8'h00, 1);
        tick();
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== 8'hB7 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL drain: y=%02h sel=%b y_valid=%b required b7 1 0", bus.y, bus.sel, bus.y_valid);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1, 1, 8'h3C, 0, 8'h00, 0);
        tick();
        drive(0, 1, 8'h44, 1, 8'h55, 1);
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_readies: a_ready=%b b_ready=%b required 0 0", bus.a_ready, bus.b_ready);
        end
        tick();
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== 8'h00 || bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: y=%02h sel=%b y_valid=%b required 00 0 0", bus.y, bus.sel, bus.y_valid);
        end
        // First tie after reset must go to A.
        drive(1, 1, 8'h61, 1, 8'h62, 1);
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tie: a_ready=%b b_ready=%b required 1 0", bus.a_ready, bus.b_ready);
        end
        tick();
    endtask

    task automatic test_random();
        bit ea;
        bit eb;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            ea = exp_a_ready();
            eb = exp_b_ready();
            checks++;
            if (bus.a_ready !== ea || bus.b_ready !== eb) begin
                errors++;
                $display("FAIL rand_ready[%0d]: a_ready=%b b_ready=%b required %b %b",
                         i, bus.a_ready, bus.b_ready, ea, eb);
            end
            tick();
            checks++;
            if (bus.y_valid !== m_full || bus.y !== m_y || bus.sel !== m_sel) begin
                errors++;
                $display("FAIL rand_out[%0d]: y=%02h sel=%b y_valid=%b required %02h %b %b",
                         i, bus.y, bus.sel, bus.y_valid, m_y, m_sel, m_full);
            end
        end
    endtask

    initial begin
        m_full = 0; m_y = 8'h00; m_sel = 0; m_last_b = 1;
        test_reset();
        test_single_a();
        test_back_to_back();
        test_backpressure();
        test_drain();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
